// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single uart_tx FIFO write port between NUM_REQ byte-stream
//   requesters. Whole packets are granted round-robin, so bytes from different
//   requesters never interleave on the line. Each write is followed by a
//   one-cycle GAP that absorbs the one-cycle lag of tx_full after a write.
//   A packet is force-released after MAX_PACKET bytes so one requester cannot
//   hog the line.
//
//   Optional feature macro: UART_ARB_CRLF_EN
//     When defined, a packet that ends on a last-flagged byte is followed by
//     CR (0x0D) and LF (0x0A) while the grant is still held. No ack is issued
//     for these bytes.
//
// Ports
//   clock_i          system clock
//   reset_i          synchronous active-high reset
//   req_i            per-requester byte-valid, held until acked
//   req_data_i       flattened bytes, requester i on [8i+7:8i]
//   req_last_i       presented byte is the last of its packet
//   grant_o          one-hot current owner, zero when idle
//   ack_o            one-cycle pulse: presented byte was written
//   tx_data_o        byte to uart_tx data_in
//   write_to_uart_o  one-cycle write strobe to uart_tx
//   tx_full_i        uart_tx buffer_full
//   busy_o           a packet is in progress
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_PACKET = 64
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [NUM_REQ-1:0]   ack_o,
    output logic [7:0]           tx_data_o,
    output logic                 write_to_uart_o,
    input  logic                 tx_full_i,
    output logic                 busy_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = IW + 1;

`ifdef UART_ARB_CRLF_EN
    typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_CR, S_LF} state_t;
    // Which terminator byte the current GAP follows.
    typedef enum logic [1:0] {T_NONE, T_CR, T_LF} tail_t;
    tail_t tail_q, tail_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`endif

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         txd_q, txd_d;
    logic               wr_q, wr_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [IW-1:0]      pick;
    logic [CW-1:0]      cand;
    logic [IW-1:0]      gnext;
    logic               rel;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        txd_d   = txd_q;
        ack_d   = '0;
        wr_d    = 1'b0;
        rel     = 1'b0;
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
`ifdef UART_ARB_CRLF_EN
        tail_d  = tail_q;
`endif

        // First requester at or after the pointer, wrapping.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end

        gnext = ({1'b0, gidx_q} == CW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gidx_d  = pick;
                    grant_d = NUM_REQ'(1) << pick;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!req_i[gidx_q]) begin
                    rel = 1'b1;
                end else if (!tx_full_i) begin
                    txd_d   = req_data_i[{gidx_q, 3'b000} +: 8];
                    wr_d    = 1'b1;
                    ack_d   = NUM_REQ'(1) << gidx_q;
                    cnt_d   = cnt_q + 8'd1;
                    last_d  = req_last_i[gidx_q];
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
`ifdef UART_ARB_CRLF_EN
                if (tail_q == T_LF)                 rel = 1'b1;
                else if (tail_q == T_CR)            state_d = S_LF;
                else if (last_q)                    state_d = S_CR;
                else if (cnt_q == 8'(MAX_PACKET))   rel = 1'b1;
                else                                state_d = S_SEND;
`else
                if (last_q || cnt_q == 8'(MAX_PACKET)) rel = 1'b1;
                else                                   state_d = S_SEND;
`endif
            end
`ifdef UART_ARB_CRLF_EN
            S_CR: begin
                if (!tx_full_i) begin
                    txd_d   = 8'h0D;
                    wr_d    = 1'b1;
                    tail_d  = T_CR;
                    state_d = S_GAP;
                end
            end
            S_LF: begin
                if (!tx_full_i) begin
                    txd_d   = 8'h0A;
                    wr_d    = 1'b1;
                    tail_d  = T_LF;
                    state_d = S_GAP;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // End of packet (normal, forced or dropped): hand the pointer on.
        if (rel) begin
            ptr_d   = gnext;
            grant_d = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = S_IDLE;
`ifdef UART_ARB_CRLF_EN
            tail_d  = T_NONE;
`endif
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            txd_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_ARB_CRLF_EN
            tail_q  <= T_NONE;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            txd_q   <= txd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
`ifdef UART_ARB_CRLF_EN
            tail_q  <= tail_d;
`endif
        end
    end

    assign grant_o         = grant_q;
    assign ack_o           = ack_q;
    assign tx_data_o       = txd_q;
    assign write_to_uart_o = wr_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_PACKET=4). Requesters
//   are queues of bytes that advance on ack; every FIFO write is logged and
//   compared with hand-written expected byte sequences.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int MP = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   req_last = '0;
    logic [8*NR-1:0] req_data = '0;
    logic            tx_full = 1'b0;
    logic [NR-1:0]   grant, ack;
    logic [7:0]      tx_data;
    logic            wr, busy;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_PACKET(MP)) dut (
        .clock_i        (clk),
        .reset_i        (rst),
        .req_i          (req),
        .req_data_i     (req_data),
        .req_last_i     (req_last),
        .grant_o        (grant),
        .ack_o          (ack),
        .tx_data_o      (tx_data),
        .write_to_uart_o(wr),
        .tx_full_i      (tx_full),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       drop;
    } ent_t;
    ent_t rq[NR][$];

    logic [7:0]    wlog[$];
    int            wcyc[$];
    logic [NR-1:0] wgnt[$];
    int            ackcnt[NR];
    logic [7:0]    exp_q[$];
    int            base = 0;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = rq[i][0].d;
                req_last[i]       = rq[i][0].last;
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic pushb(input int i, input logic [7:0] d, input logic l);
        ent_t e;
        e.d = d; e.last = l; e.drop = 1'b0;
        rq[i].push_back(e);
    endtask

    task automatic pushdrop(input int i);
        ent_t e;
        e.d = 8'h00; e.last = 1'b0; e.drop = 1'b1;
        rq[i].push_back(e);
    endtask

    // Expected byte; el() also appends the terminator when CRLF is built in.
    task automatic e(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    task automatic el(input logic [7:0] b);
        exp_q.push_back(b);
`ifdef UART_ARB_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // Requester model: after ack, present the next byte or drop req.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (ack[i] === 1'b1 && rq[i].size() > 0) begin
                    void'(rq[i].pop_front());
                    if (rq[i].size() > 0 && rq[i][0].drop) void'(rq[i].pop_front());
                end
            end
            drive();
        end
    end

    // Write monitor.
    initial begin
        for (int i = 0; i < NR; i++) ackcnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wr === 1'b1) begin
                wlog.push_back(tx_data);
                wcyc.push_back(cyc);
                wgnt.push_back(grant);
            end
            for (int i = 0; i < NR; i++) if (ack[i] === 1'b1) ackcnt[i]++;
        end
    end

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'h0);
        chk({tag, "_ack"},   32'(ack),   32'h0);
        chk({tag, "_wr"},    32'(wr),    32'h0);
        chk({tag, "_data"},  32'(tx_data), 32'h0);
        chk({tag, "_busy"},  32'(busy),  32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        drive();
        tick();
        chk_idle_outs(tag);
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_n(input string tag, input int n);
        int k = 0;
        while (wlog.size() < n && k < 500) begin
            tick();
            k++;
        end
        chk({tag, "_wait"}, 32'(wlog.size() >= n), 32'h1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while ((wlog.size() < base + exp_q.size() || busy !== 1'b0) && k < 600) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 32'(k < 600), 32'h1);
        repeat (6) tick();
    endtask

    task automatic chk_seq(input string tag);
        logic [31:0] got;
        chk({tag, "_count"}, 32'(wlog.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++) begin
            got = (base + k < wlog.size()) ? 32'(wlog[base + k]) : 32'hFFFF_FFFF;
            chk($sformatf("%s_byte%0d", tag, k), got, 32'(exp_q[k]));
        end
        base = wlog.size();
        exp_q.delete();
    endtask

    initial begin
        int rel_cyc;
        int nwr;
        int badg;

        do_reset("reset");

        // Single requester, pointer 0.
        pushb(0, 8'h41, 1'b0);
        pushb(0, 8'h42, 1'b1);
        drive();
        e(8'h41); el(8'h42);
        wait_done("single");
        chk("single_grant_at_write", (wgnt.size() > base) ? 32'(wgnt[base]) : 32'hFFFF_FFFF, 32'h1);
        for (int k = 1; k < exp_q.size(); k++)
            chk($sformatf("single_spacing%0d", k),
                (wcyc.size() > base + k) ? 32'(wcyc[base + k] - wcyc[base + k - 1]) : 32'hFFFF_FFFF,
                32'd2);
        chk("single_acks", 32'(ackcnt[0]), 32'd2);
        chk("single_grant_after", 32'(grant), 32'h0);
        chk("single_busy_after", 32'(busy), 32'h0);
        chk_seq("single");

        // Contention from pointer 0: req0 whole packet then req2.
        do_reset("reset2");
        pushb(0, 8'h10, 1'b0); pushb(0, 8'h11, 1'b0); pushb(0, 8'h12, 1'b1);
        pushb(2, 8'h20, 1'b0); pushb(2, 8'h21, 1'b0); pushb(2, 8'h22, 1'b1);
        drive();
        e(8'h10); e(8'h11); el(8'h12); e(8'h20); e(8'h21); el(8'h22);
        wait_done("contend");
        chk_seq("contend");

        // Pointer 3: req0 wins, then re-asserts immediately but req1 goes first.
        pushb(0, 8'h30, 1'b1); pushb(0, 8'h31, 1'b1);
        pushb(1, 8'h50, 1'b1);
        drive();
        el(8'h30); el(8'h50); el(8'h31);
        wait_done("reassert");
        chk_seq("reassert");

        // Backpressure mid-packet on req1 (pointer 1).
        pushb(1, 8'h80, 1'b0); pushb(1, 8'h81, 1'b0); pushb(1, 8'h82, 1'b1);
        drive();
        wait_n("bp_first", base + 1);
        tx_full = 1'b1;
        nwr = 0;
        badg = 0;
        repeat (20) begin
            tick();
            if (wr !== 1'b0) nwr++;
            if (grant !== 4'b0010) badg++;
        end
        chk("bp_stall_writes", 32'(nwr), 32'h0);
        chk("bp_stall_grant", 32'(badg), 32'h0);
        tx_full = 1'b0;
        rel_cyc = cyc;
        e(8'h80); e(8'h81); el(8'h82);
        wait_done("bp");
        chk("bp_resume_latency",
            (wcyc.size() > base + 1) ? 32'(wcyc[base + 1] - rel_cyc) : 32'hFFFF_FFFF, 32'd1);
        chk_seq("bp");

        // MAX_PACKET forced release: req1 6 bytes, req3 waiting.
        do_reset("reset4");
        for (int k = 0; k < 6; k++) pushb(1, 8'h90 + 8'(k), (k == 5));
        pushb(3, 8'hA0, 1'b0); pushb(3, 8'hA1, 1'b1);
        drive();
        e(8'h90); e(8'h91); e(8'h92); e(8'h93);
        e(8'hA0); el(8'hA1);
        e(8'h94); el(8'h95);
        wait_done("maxpkt");
        chk_seq("maxpkt");

        // Dropped request: req2 drops after its first ack; pointer becomes 3.
        do_reset("reset5");
        pushb(2, 8'hB0, 1'b0); pushdrop(2);
        drive();
        e(8'hB0);
        wait_done("drop");
        chk("drop_grant", 32'(grant), 32'h0);
        chk("drop_busy", 32'(busy), 32'h0);
        chk_seq("drop");
        pushb(0, 8'hC0, 1'b1);
        pushb(3, 8'hD0, 1'b1);
        drive();
        el(8'hD0); el(8'hC0);
        wait_done("drop_ptr");
        chk_seq("drop_ptr");

        // Move pointer to 3, then reset in SEND after req2's first byte.
        pushb(2, 8'h5A, 1'b1);
        drive();
        el(8'h5A);
        wait_done("pre_rst");
        chk_seq("pre_rst");
        pushb(2, 8'hE0, 1'b0); pushb(2, 8'hE1, 1'b0); pushb(2, 8'hE2, 1'b1);
        drive();
        wait_n("midrst_first", base + 1);
        tick();
        chk("midrst_grant_before", 32'(grant), 32'h4);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        drive();
        tick();
        chk_idle_outs("midrst");
        rst = 1'b0;
        repeat (6) tick();
        e(8'hE0);
        chk_seq("midrst");
        pushb(1, 8'hF0, 1'b1);
        pushb(3, 8'hF3, 1'b1);
        drive();
        el(8'hF0); el(8'hF3);
        wait_done("post_rst");
        chk_seq("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
